// File: rtl/cpu7_ifu_imem_resp.sv
// cpu7_ifu_imem_resp -- responder end of the IFU instruction-fetch interface.
//
// Accepts one fetch at a time from the fetch unit and answers it exactly
// LATENCY cycles later from a fixed-latency synchronous instruction SRAM.
// Misaligned or out-of-window addresses are flagged as ADEF (exccode 6'h08)
// without touching the SRAM, but still take LATENCY cycles so responses stay
// in order. inst_cancel kills every response not yet delivered.
//
// Ports:
//   clock, resetn        clock (rising edge), async active-low reset
//   inst_req/inst_addr   fetch request and byte address
//   inst_cancel          kill all not-yet-delivered responses
//   inst_addr_ok         request accepted this cycle (when inst_req=1)
//   inst_valid_f         response valid; rdata/ex/exccode/uncache qualify it
//   inst_count           instructions per response (always 1)
//   sram_en/sram_addr    SRAM read strobe and word address
//   sram_rdata           SRAM data, LATENCY cycles after sram_en
//   perf_fetch_cnt,      (only with CPU7_IMEM_RESP_PERF_EN) accepted fetches
//   perf_kill_cnt        and suppressed response slots
//
// Optional feature macro: CPU7_IMEM_RESP_PERF_EN.

`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_ifu_imem_resp #(
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned AW           = 14,
  parameter logic [31:0] MEM_BASE     = 32'h1c000000,
  parameter logic [31:0] UNCACHE_BASE = 32'ha0000000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_valid_f,
  output logic [`GRLEN-1:0] inst_rdata_f,
  output logic [1:0]        inst_count,
  output logic              inst_ex,
  output logic [5:0]        inst_exccode,
  output logic              inst_uncache,
  output logic              sram_en,
  output logic [AW-1:0]     sram_addr,
  input  logic [31:0]       sram_rdata
`ifdef CPU7_IMEM_RESP_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_kill_cnt
`endif
);

  // Single outstanding fetch slot.
  typedef struct packed {
    logic       pend;    // a fetch is in flight
    logic [2:0] cnt;     // cycles left until its response cycle
    logic       killed;  // cancelled while in flight
    logic       ex;      // ADEF
    logic       unc;     // uncached attribute
  } slot_t;

  // 33-bit end of the SRAM window so a window touching 2^32 cannot wrap.
  localparam logic [32:0] MEM_END  = {1'b0, MEM_BASE} + (33'd4 << AW);
  localparam logic [2:0]  CNT_INIT = 3'(LATENCY - 1);

  slot_t cur, nxt;
  logic  resp, accept, deliver, addr_ex, addr_unc;

  assign resp         = cur.pend & (cur.cnt == 3'd0);
  assign inst_addr_ok = ~cur.pend | (cur.cnt == 3'd0);
  // resetn gate keeps sram_en quiet while reset is asserted.
  assign accept       = resetn & inst_req & inst_addr_ok;
  assign deliver      = resp & ~cur.killed & ~inst_cancel;

  assign addr_ex  = (inst_addr[1:0] != 2'b00) | (inst_addr < MEM_BASE) |
                    ({1'b0, inst_addr} >= MEM_END);
  assign addr_unc = inst_addr >= UNCACHE_BASE;

  // Response side: every sideband reads zero unless the response is valid.
  assign inst_valid_f = deliver;
  assign inst_rdata_f = (deliver & ~cur.ex) ? `GRLEN'(sram_rdata) : '0;
  assign inst_ex      = deliver & cur.ex;
  assign inst_exccode = (deliver & cur.ex) ? 6'h08 : 6'h00;
  assign inst_uncache = deliver & cur.unc;
  assign inst_count   = 2'd1;

  // Faulting fetches never reach the SRAM.
  assign sram_en   = accept & ~addr_ex;
  assign sram_addr = sram_en ? AW'((inst_addr - MEM_BASE) >> 2) : '0;

  always_comb begin
    nxt = cur;
    if (accept) begin
      // Covers the response-and-accept cycle too: old slot retires, new loads.
      nxt.pend   = 1'b1;
      nxt.cnt    = CNT_INIT;
      nxt.killed = 1'b0;
      nxt.ex     = addr_ex;
      nxt.unc    = addr_unc;
    end else if (resp) begin
      nxt = '0;
    end else if (cur.pend) begin
      // Mid-flight (cnt != 0 here): count down; a cancel marks the slot dead
      // and the SRAM read finishes unobserved.
      nxt.cnt = cur.cnt - 3'd1;
      if (inst_cancel) nxt.killed = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cur <= '0;
    else         cur <= nxt;
  end

`ifdef CPU7_IMEM_RESP_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (accept)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (resp & ~deliver) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu7_ifu_imem_resp.sv
// Self-checking bench for cpu7_ifu_imem_resp. Four configurations run in
// parallel (LATENCY 1/3/2/4, one with MEM_BASE=0xa0000000 and AW=10), each
// with its own SRAM model and a transaction-level reference model: a queue of
// outstanding fetches tagged with the cycle their answer is due.

`ifndef GRLEN
`define GRLEN 32
`endif

module tb_cpu7_ifu_imem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;

  typedef struct {
    longint      due;
    bit          killed;
    bit          ex;
    bit          unc;
    logic [31:0] word;
    logic [31:0] data;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM contents as a function of word address.
  function automatic logic [31:0] memf(input logic [31:0] w);
    return (w * 32'h0001_0003) ^ 32'h5a5a_0000 ^ {w[15:0], 16'h0};
  endfunction

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int          L    = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 2 : 4;
    localparam int          AWG  = (g == 3) ? 10 : 14;
    localparam logic [31:0] BASE = (g == 3) ? 32'ha0000000 : 32'h1c000000;

    logic              rst_n, req, cancel, ok, vld, ex, unc, sen;
    logic [31:0]       addr, srd;
    logic [`GRLEN-1:0] rdata;
    logic [1:0]        icnt;
    logic [5:0]        ecode;
    logic [AWG-1:0]    saddr;
`ifdef CPU7_IMEM_RESP_PERF_EN
    logic [31:0]       pf, pk;
`endif

    cpu7_ifu_imem_resp #(
      .LATENCY(L), .AW(AWG), .MEM_BASE(BASE), .UNCACHE_BASE(32'ha0000000)
    ) u_dut (
      .clock(clk), .resetn(rst_n), .inst_req(req), .inst_addr(addr),
      .inst_cancel(cancel), .inst_addr_ok(ok), .inst_valid_f(vld),
      .inst_rdata_f(rdata), .inst_count(icnt), .inst_ex(ex),
      .inst_exccode(ecode), .inst_uncache(unc), .sram_en(sen),
      .sram_addr(saddr), .sram_rdata(srd)
`ifdef CPU7_IMEM_RESP_PERF_EN
      , .perf_fetch_cnt(pf), .perf_kill_cnt(pk)
`endif
    );

    // L-deep SRAM read pipe; junk when not strobed so stray use shows up.
    logic [31:0] pipe [L];
    always @(posedge clk) begin
      pipe[0] <= sen ? memf(32'(saddr)) : 32'hffff_ffff;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign srd = pipe[L-1];

    exp_t   q[$];
    longint cyc = 0;
    int     fetch_n = 0, kill_n = 0;
    bit     last_acc;

    function automatic string tag(input string s);
      return $sformatf("g%0d.%s@%0d", g, s, cyc);
    endfunction

    function automatic exp_t predict(input logic [31:0] a);
      exp_t        e;
      longint      lim;
      logic [31:0] off;
      lim    = longint'({32'h0, BASE}) + (longint'(4) << AWG);
      off    = a - BASE;
      e.due  = 0;
      e.killed = 0;
      e.ex   = (a[1:0] != 2'b00) || (a < BASE) || (longint'({32'h0, a}) >= lim);
      e.unc  = a >= 32'ha0000000;
      e.word = (off >> 2) & ((32'd1 << AWG) - 32'd1);
      e.data = e.ex ? 32'h0 : memf(e.word);
      return e;
    endfunction

    function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 7))
        0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, (1 << AWG) - 1));
        4:          return (BASE + 32'($urandom_range(0, 4095))) | 32'h1;
        5:          return BASE - 32'(4 * $urandom_range(1, 4));
        6:          return BASE + (32'd4 << AWG) + 32'(4 * $urandom_range(0, 2)) - 32'd4;
        default:    return $urandom;
      endcase
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance the model.
    task automatic step(input bit rq, input logic [31:0] a, input bit cn);
      exp_t e;
      bit   due, eok, evld, acc;
      req = rq; addr = a; cancel = cn;
      @(negedge clk);
      due  = (q.size() != 0) && (q[0].due == cyc);
      eok  = (q.size() == 0) || due;
      evld = due && !q[0].killed && !cn;
      e    = predict(a);
      acc  = rq && eok;
      chk(tag("addr_ok"), ok, eok);
      chk(tag("valid"), vld, evld);
      chk(tag("count"), icnt, 2'd1);
      if (evld) begin
        chk(tag("rdata"), rdata, q[0].data);
        chk(tag("ex"), ex, q[0].ex);
        chk(tag("exccode"), ecode, q[0].ex ? 6'h08 : 6'h00);
        chk(tag("uncache"), unc, q[0].unc);
      end else begin
        chk(tag("rdata_idle"), rdata, 0);
        chk(tag("side_idle"), {ex, unc, ecode}, 0);
      end
      chk(tag("sram_en"), sen, acc && !e.ex);
      chk(tag("sram_addr"), saddr, (acc && !e.ex) ? e.word : 0);
      if (due) begin
        if (!evld) kill_n++;
        void'(q.pop_front());
      end else if (cn && q.size() != 0) begin
        q[0].killed = 1;
      end
      if (acc) begin
        e.due = cyc + L;
        q.push_back(e);
        fetch_n++;
      end
      last_acc = acc;
      cyc++;
      @(posedge clk);
      #1;
    endtask

    task automatic idle(input int n);
      repeat (n) step(0, $urandom, 0);
    endtask

    // Keep presenting a until accepted (bounded).
    task automatic hold(input logic [31:0] a);
      int k = 0;
      last_acc = 0;
      while (!last_acc && k < 8) begin
        step(1, a, 0);
        k++;
      end
      if (!last_acc) chk(tag("hold_timeout"), 0, 1);
    endtask

    // Async reset pulse from a step-aligned point with a request presented.
    task automatic pulse_reset();
      req = 1; addr = BASE; cancel = 0;
      rst_n = 0;
      #1;
      chk(tag("rst_valid"), vld, 0);
      chk(tag("rst_side"), {ex, unc, ecode}, 0);
      chk(tag("rst_rdata"), rdata, 0);
      chk(tag("rst_sram"), {sen, saddr}, 0);
      chk(tag("rst_addr_ok"), ok, 1);
`ifdef CPU7_IMEM_RESP_PERF_EN
      chk(tag("rst_perf"), {pf, pk}, 0);
`endif
      req = 0;
      @(negedge clk);
      rst_n = 1;
      q.delete();
      fetch_n = 0;
      kill_n  = 0;
      @(posedge clk);
      #1;
      cyc++;
    endtask

    initial begin
      rst_n = 0; req = 0; cancel = 0; addr = 0;
      @(posedge clk);
      #1;
      pulse_reset();
      // back-to-back fetches of words 0,1,2
      for (int i = 0; i < 3; i++) step(1, BASE + 32'(4 * i), 0);
      idle(L + 1);
      // misaligned, then out of range
      step(1, BASE + 32'd2, 0);  idle(L);
      step(1, 32'h0, 0);         idle(L);
      // request held while addr_ok is low
      step(1, BASE + 32'h10, 0);
      hold(BASE + 32'h14);
      idle(L + 1);
      // cancel with the redirect target presented in the same cycle
      step(1, BASE, 0);
      step(1, BASE + 32'h100, 1);
      if (!last_acc) hold(BASE + 32'h100);
      idle(L + 1);
      // cancel landing in the response cycle
      step(1, BASE + 32'h8, 0);
      idle(L - 1);
      step(0, 0, 1);
      idle(L + 1);
      // uncached address
      step(1, 32'ha0000000, 0);
      idle(L + 1);
      // reset pulsed while a fetch is in flight; next request goes straight in
      step(1, BASE + 32'hc, 0);
      pulse_reset();
      idle(L + 1);
      step(1, BASE + 32'h4, 0);
      idle(L + 1);
      // randomized traffic
      repeat (400) step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 9) == 0);
      idle(L + 1);
`ifdef CPU7_IMEM_RESP_PERF_EN
      chk(tag("perf_fetch"), pf, 32'(fetch_n));
      chk(tag("perf_kill"), pk, 32'(kill_n));
`endif
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && n_done < 4; i++) @(posedge clk);
    chk("all_done", n_done, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
